// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM states, grant
// encoding and the arbitration priority rule.
package mem_arb_pkg;

    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_GNT_INS  = 2'd1,
        ARB_GNT_DATA = 2'd2
    } arb_state_t;

    // One-hot grant; both bits clear means nobody is granted.
    typedef struct packed {
        logic ins;
        logic data;
    } grant_t;

    function automatic grant_t arbitrate(input logic req_d, input logic req_i,
                                         input logic starved);
        grant_t g;
        g = '0;
        if (req_d && req_i && starved) g.ins  = 1'b1;
        else if (req_d)                g.data = 1'b1;
        else if (req_i)                g.ins  = 1'b1;
        return g;
    endfunction

    function automatic arb_state_t grant_to_state(input grant_t g);
        if (g.data) return ARB_GNT_DATA;
        if (g.ins)  return ARB_GNT_INS;
        return ARB_IDLE;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Standard memory_interface bundle (addr/din/dout/mask/read/write/busy).
// master drives the request side, slave answers with dout/busy.
interface mem_port_arbiter_if #(
    parameter int AN = 30,
    parameter int DN = 32
);
    logic [AN-1:0]   addr;
    logic [DN-1:0]   din;
    logic [DN-1:0]   dout;
    logic [DN/8-1:0] mask;
    logic            read;
    logic            write;
    logic            busy;

    modport master (output addr, din, mask, read, write, input dout, busy);
    modport slave  (input addr, din, mask, read, write, output dout, busy);
endinterface

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of arbitrations the fetch port has lost since its last
// completed transfer; o_sat marks that fetch must win next.
module mem_arb_starve_cnt #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);
    localparam int           W   = $clog2(LIMIT + 1);
    localparam logic [W-1:0] MAX = W'(LIMIT);

    logic [W-1:0] r_cnt;

    // A fetch completing in the same cycle it loses the next decision restarts at 1.
    always_ff @(posedge clk) begin
        if (reset)                      r_cnt <= '0;
        else if (i_clr)                 r_cnt <= W'(i_inc);
        else if (i_inc && r_cnt != MAX) r_cnt <= r_cnt + W'(1);
    end

    assign o_sat = (r_cnt == MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data ports.
// Data has priority; fetch is guaranteed a grant after STARVE_LIMIT losses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AN           = 30,
    parameter int DN           = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  ins_if,
    mem_port_arbiter_if.slave  data_if,
    mem_port_arbiter_if.master mem_if
);

    arb_state_t r_state;

    logic            w_req_d, w_req_i, w_own_req;
    logic            w_done, w_decide, w_clr, w_inc, w_sat;
    grant_t          w_gnt;
    logic [AN-1:0]   w_mem_addr;
    logic [DN-1:0]   w_mem_din, w_ins_dout, w_data_dout;
    logic [DN/8-1:0] w_mem_mask;
    logic            w_mem_read, w_mem_write, w_ins_busy, w_data_busy;

    assign w_req_d = data_if.read | data_if.write;
    assign w_req_i = ins_if.read;

    always_comb begin
        w_own_req = 1'b0;
        case (r_state)
            ARB_GNT_INS:  w_own_req = w_req_i;
            ARB_GNT_DATA: w_own_req = w_req_d;
            default:      w_own_req = 1'b0;
        endcase
    end

    assign w_done   = (r_state != ARB_IDLE) && w_own_req && !mem_if.busy;
    assign w_decide = (r_state == ARB_IDLE) || w_done;
    assign w_clr    = w_done && (r_state == ARB_GNT_INS);
    // A completing fetch has just been served, so its stale saturation must not
    // hand it a second grant in a row.
    assign w_gnt    = arbitrate(w_req_d, w_req_i, w_sat & ~w_clr);
    assign w_inc    = w_decide && w_gnt.data && w_req_i;

    mem_arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_inc),
        .i_clr (w_clr),
        .o_sat (w_sat)
    );

    always_ff @(posedge clk) begin
        if (reset)           r_state <= ARB_IDLE;
        else if (w_decide)   r_state <= grant_to_state(w_gnt);
        else if (!w_own_req) r_state <= ARB_IDLE;
    end

    always_comb begin
        w_mem_addr  = '0;
        w_mem_din   = '0;
        w_mem_mask  = '0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_ins_busy  = w_req_i;
        w_data_busy = w_req_d;
        w_ins_dout  = '0;
        w_data_dout = '0;
        case (r_state)
            ARB_GNT_DATA: begin
                w_mem_addr  = data_if.addr;
                w_mem_din   = data_if.din;
                w_mem_mask  = data_if.mask;
                w_mem_read  = data_if.read;
                w_mem_write = data_if.write;
                w_data_busy = mem_if.busy;
                w_data_dout = mem_if.dout;
            end
            ARB_GNT_INS: begin
                // Strobe follows the request so an aborting fetch drives nothing.
                w_mem_addr  = ins_if.addr;
                w_mem_read  = ins_if.read;
                w_ins_busy  = mem_if.busy;
                w_ins_dout  = mem_if.dout;
            end
            default: ;
        endcase
    end

    assign mem_if.addr   = w_mem_addr;
    assign mem_if.din    = w_mem_din;
    assign mem_if.mask   = w_mem_mask;
    assign mem_if.read   = w_mem_read;
    assign mem_if.write  = w_mem_write;
    assign ins_if.busy   = w_ins_busy;
    assign ins_if.dout   = w_ins_dout;
    assign data_if.busy  = w_data_busy;
    assign data_if.dout  = w_data_dout;

    a_write_only_data: assert property (@(posedge clk) disable iff (reset)
        w_mem_write |-> (r_state == ARB_GNT_DATA));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared each cycle against an ownership model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AN  = 30;
    localparam int DN  = 32;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AN(AN), .DN(DN)) ins_if ();
    mem_port_arbiter_if #(.AN(AN), .DN(DN)) data_if ();
    mem_port_arbiter_if #(.AN(AN), .DN(DN)) mem_if ();

    mem_port_arbiter #(.AN(AN), .DN(DN), .STARVE_LIMIT(LIM)) dut (
        .clk     (clk),
        .reset   (reset),
        .ins_if  (ins_if),
        .data_if (data_if),
        .mem_if  (mem_if)
    );

    int n_pass = 0;
    int n_tot  = 0;

    // Model: who owns the memory (0 nobody, 1 fetch, 2 data) and how many
    // arbitrations fetch has lost since it was last served.
    int m_own  = 0;
    int m_lost = 0;
    bit m_valid = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_check();
        logic          rd, eib, edb, er, ew;
        logic [AN-1:0] ea;
        logic [DN-1:0] ed;
        logic [3:0]    em;
        if (!m_valid) return;
        rd  = data_if.read | data_if.write;
        ea  = '0; ed = '0; em = '0; er = 1'b0; ew = 1'b0;
        eib = ins_if.read;
        edb = rd;
        if (m_own == 1) begin
            ea = ins_if.addr; er = ins_if.read; eib = mem_if.busy;
        end else if (m_own == 2) begin
            ea = data_if.addr; ed = data_if.din; em = data_if.mask;
            er = data_if.read; ew = data_if.write; edb = mem_if.busy;
        end
        chk("mem_addr", 64'(mem_if.addr), 64'(ea));
        if (m_own != 1) chk("mem_din", 64'(mem_if.din), 64'(ed));
        chk("mem_mask",  64'(mem_if.mask),  64'(em));
        chk("mem_read",  64'(mem_if.read),  64'(er));
        chk("mem_write", 64'(mem_if.write), 64'(ew));
        chk("ins_busy",  64'(ins_if.busy),  64'(eib));
        chk("data_busy", 64'(data_if.busy), 64'(edb));
        if (ins_if.read && !eib)  chk("ins_dout",  64'(ins_if.dout),  64'(mem_if.dout));
        if (data_if.read && !edb) chk("data_dout", 64'(data_if.dout), 64'(mem_if.dout));
    endtask

    task automatic model_step();
        bit rd, ri, own, decide;
        if (reset) begin
            m_own = 0; m_lost = 0; m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        rd = data_if.read | data_if.write;
        ri = ins_if.read;
        decide = 1'b0;
        if (m_own == 0) decide = 1'b1;
        else begin
            own = (m_own == 1) ? ri : rd;
            if (!own) m_own = 0;
            else if (!mem_if.busy) begin
                decide = 1'b1;
                if (m_own == 1) m_lost = 0;
            end
        end
        if (decide) begin
            if (rd && ri && m_lost == LIM) m_own = 1;
            else if (rd) begin
                m_own = 2;
                if (ri && m_lost < LIM) m_lost++;
            end
            else if (ri) m_own = 1;
            else m_own = 0;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic ir, input logic [AN-1:0] ia,
                         input logic dr, input logic dw, input logic [AN-1:0] da,
                         input logic [DN-1:0] dd, input logic [3:0] dm,
                         input logic mb, input logic [DN-1:0] mdo);
        ins_if.read  = ir;  ins_if.addr  = ia;
        data_if.read = dr;  data_if.write = dw; data_if.addr = da;
        data_if.din  = dd;  data_if.mask  = dm;
        mem_if.busy  = mb;  mem_if.dout   = mdo;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, '0, 0, 0, '0, '0, '0, 0, '0);
        settle(); tick();
        settle(); tick();
        reset = 1'b0;
    endtask

    initial begin
        string  exp_seq;
        byte    seq;

        ins_if.write = 1'b0; ins_if.din = '0; ins_if.mask = '0;
        drive(0, '0, 0, 0, '0, '0, '0, 0, '0);

        // Reset state: requesters present, nothing granted yet.
        do_reset();
        drive(1, 30'h1, 1, 0, 30'h2, '0, '0, 0, '0);
        settle();
        chk("rst_mem_read",  64'(mem_if.read),  64'(0));
        chk("rst_mem_write", 64'(mem_if.write), 64'(0));
        chk("rst_mem_addr",  64'(mem_if.addr),  64'(0));
        chk("rst_ins_busy",  64'(ins_if.busy),  64'(1));
        chk("rst_data_busy", 64'(data_if.busy), 64'(1));
        tick();

        // Reset while a data write is stalled in flight.
        do_reset();
        drive(0, '0, 0, 1, 30'h20, 32'hA5A5_0000, 4'hF, 1, '0);
        settle(); tick();
        settle();
        chk("inflight_write", 64'(mem_if.write), 64'(1));
        tick();
        reset = 1'b1;
        settle(); tick();
        reset = 1'b0;
        settle();
        chk("rstmid_write",     64'(mem_if.write), 64'(0));
        chk("rstmid_read",      64'(mem_if.read),  64'(0));
        chk("rstmid_data_busy", 64'(data_if.busy), 64'(1));
        tick();

        // Lone fetch: one arbitration cycle then one service cycle.
        do_reset();
        drive(1, 30'h10, 0, 0, '0, '0, '0, 0, 32'hDEAD_BEEF);
        settle();
        chk("fetch_c0_busy", 64'(ins_if.busy),  64'(1));
        chk("fetch_c0_read", 64'(mem_if.read),  64'(0));
        tick();
        settle();
        chk("fetch_c1_read", 64'(mem_if.read), 64'(1));
        chk("fetch_c1_addr", 64'(mem_if.addr), 64'(30'h10));
        chk("fetch_c1_busy", 64'(ins_if.busy), 64'(0));
        chk("fetch_c1_dout", 64'(ins_if.dout), 64'(32'hDEAD_BEEF));
        tick();

        // Fetch held against continuous data traffic: 4 data services, then
        // fetch, with the 4th data service being a masked write.
        do_reset();
        exp_seq = "-DDDWIDDDDID";
        drive(1, 30'h200, 1, 0, 30'h100, '0, '0, 0, 32'h1111_2222);
        for (int k = 0; k < 12; k++) begin
            if (k == 4) drive(1, 30'h200, 0, 1, 30'h20, 32'h1234_5678, 4'hF, 0, 32'h1111_2222);
            if (k == 5) drive(1, 30'h200, 1, 0, 30'h100, '0, '0, 0, 32'h1111_2222);
            settle();
            if (mem_if.read && mem_if.addr == 30'h100)       seq = "D";
            else if (mem_if.write && mem_if.addr == 30'h20)  seq = "W";
            else if (mem_if.read && mem_if.addr == 30'h200)  seq = "I";
            else                                             seq = "-";
            chk($sformatf("grant_seq[%0d]", k), 64'(seq), 64'(exp_seq[k]));
            if (k == 4) begin
                chk("wr_din",       64'(mem_if.din),   64'(32'h1234_5678));
                chk("wr_mask",      64'(mem_if.mask),  64'(4'hF));
                chk("wr_data_busy", 64'(data_if.busy), 64'(0));
                chk("wr_ins_busy",  64'(ins_if.busy),  64'(1));
            end
            tick();
        end

        // Stalled data grant, re-grant, then abort handing over to fetch.
        do_reset();
        drive(1, 30'h66, 1, 0, 30'h55, '0, '0, 1, 32'hCAFE_F00D);
        settle(); tick();
        for (int k = 1; k <= 3; k++) begin
            settle();
            chk("hold_data_busy", 64'(data_if.busy), 64'(1));
            chk("hold_ins_busy",  64'(ins_if.busy),  64'(1));
            chk("hold_addr",      64'(mem_if.addr),  64'(30'h55));
            tick();
        end
        mem_if.busy = 1'b0;
        settle();
        chk("done_data_busy", 64'(data_if.busy), 64'(0));
        chk("done_data_dout", 64'(data_if.dout), 64'(32'hCAFE_F00D));
        tick();
        mem_if.busy = 1'b1;
        settle();
        chk("regrant_addr", 64'(mem_if.addr), 64'(30'h55));
        chk("regrant_read", 64'(mem_if.read), 64'(1));
        tick();
        data_if.read = 1'b0;
        settle();
        chk("abort_read", 64'(mem_if.read), 64'(0));
        tick();
        mem_if.busy = 1'b0;
        settle();
        chk("abort_idle_read", 64'(mem_if.read), 64'(0));
        chk("abort_idle_ibsy", 64'(ins_if.busy), 64'(1));
        tick();
        settle();
        chk("after_abort_read", 64'(mem_if.read), 64'(1));
        chk("after_abort_addr", 64'(mem_if.addr), 64'(30'h66));
        chk("after_abort_ibsy", 64'(ins_if.busy), 64'(0));
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 149) == 0);
            drive($urandom_range(0, 3) != 0, AN'($urandom),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, AN'($urandom),
                  $urandom, 4'($urandom), $urandom_range(0, 2) == 0, $urandom);
            settle();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory backend between the instruction-fetch requester and the data requester.
- The memory side presents the standard memory_interface signal set (addr, din, dout, mask, read, write, busy).
- Sits between the core's fetch/load-store ports and a unified RAM. Replaces the static "ins_busy when both hit the same bank" rule with a sequenced, starvation-bounded arbiter.
- Policy: data has priority; instruction fetch is guaranteed service after a bounded wait.

Parameters:
- AN, 30, address width in words (both requesters and memory side).
- DN, 32, data width.
- STARVE_LIMIT, 4, number of consecutive lost arbitrations after which instruction fetch wins the next arbitration.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- ins_read  in  1  fetch request
- ins_addr  in  AN  fetch word address
- ins_dout  out  DN  fetch data, valid when ins_read=1 and ins_busy=0
- ins_busy  out  1  fetch stall
- data_read  in  1  load request
- data_write  in  1  store request
- data_addr  in  AN  data word address
- data_din  in  DN  store data
- data_mask  in  DN/8  byte-lane write mask
- data_dout  out  DN  load data, valid when data_read=1 and data_busy=0
- data_busy  out  1  data stall
- mem_addr  out  AN  backend address
- mem_din  out  DN  backend write data
- mem_mask  out  DN/8  backend byte mask
- mem_read  out  1  backend read strobe
- mem_write  out  1  backend write strobe
- mem_dout  in  DN  backend read data
- mem_busy  in  1  backend stall

Behaviour:
- FSM states: IDLE, GNT_INS, GNT_DATA. All state is registered on clk.
- Reset: state=IDLE, starve_cnt=0. Reset has priority over every other event, including a transfer in flight.
- Reset outputs: mem_read=0, mem_write=0, mem_addr=0, mem_din=0, mem_mask=0, ins_busy=ins_read, data_busy=(data_read|data_write), dout='0.
- Request terms: req_d = data_read|data_write; req_i = ins_read.
- Arbitration is evaluated in IDLE, and in a GNT state on its completion cycle:
  - req_d and req_i with starve_cnt==STARVE_LIMIT -> GNT_INS.
  - Otherwise, req_d -> GNT_DATA.
  - Otherwise, req_i -> GNT_INS.
  - No request -> IDLE.
- A grant takes effect the cycle after the decision. Minimum request-to-completion latency is 2 cycles (1 arbitration cycle + 1 service cycle with mem_busy=0).
- IDLE: all mem strobes 0. Every active requester sees busy=1.
- GNT_DATA:
  - mem_addr=data_addr, mem_din=data_din, mem_mask=data_mask, mem_read=data_read, mem_write=data_write.
  - data_busy=mem_busy; data_dout=mem_dout.
  - ins_busy=ins_read.
- GNT_INS:
  - mem_addr=ins_addr, mem_read=1, mem_write=0, mem_mask=0.
  - ins_busy=mem_busy; ins_dout=mem_dout.
  - data_busy=req_d.
- Completion occurs in a GNT state when mem_busy=0. The owner's transfer retires that cycle and the next state is chosen by re-arbitration, so back-to-back grants need no IDLE bubble.
- While mem_busy=1 the grant is held; the owner must hold addr/din/mask stable.
- Abort: if the owner drops its request while granted, the next state is IDLE, no strobe is driven that cycle, and the counter is unchanged.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on every arbitration decision in which req_i=1 and data is granted.
  - Clears to 0 when a fetch completes.
  - Width is clog2(STARVE_LIMIT+1).
- Data read and write asserted together: both are passed through. The backend resolves them as a write-with-readback.
- The arbiter never asserts mem_write outside GNT_DATA. This is checked by an assertion.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum arb_state_t {ARB_IDLE, ARB_GNT_INS, ARB_GNT_DATA};
  - the grant encoding;
  - the default STARVE_LIMIT constant.
- One sub-module: mem_arb_starve_cnt, a saturating counter with inc, clr and sat output, parameterised by limit.
- The FSM and output muxing stay in mem_port_arbiter.

Test Plan:
- Reset mid-GNT_DATA with mem_busy=1 -> next cycle state IDLE, mem_write=0, starve_cnt=0.
- Only ins_read at addr 0x10, mem_busy=0, mem_dout=0xDEADBEEF -> cycle 0: ins_busy=1; cycle 1: mem_read=1, mem_addr=0x10, ins_busy=0, ins_dout=0xDEADBEEF.
- Simultaneous ins_read and data_write (addr 0x20, din 0x1234_5678, mask 0xF) -> data granted first, mem_write=1 for 1 cycle with those values, ins served the following cycle with no IDLE bubble.
- ins_read held high, data requests continuous, STARVE_LIMIT=4 -> exactly 4 data grants, then 1 fetch grant, then counter back to 0.
- Granted data with mem_busy high for 3 cycles -> grant held 3 cycles, data_busy=1, ins_busy=1. Completes on cycle 4, then re-arbitrates.
- Owner drops data_read while mem_busy=1 -> next cycle IDLE, mem_read=0, a pending ins_read is granted the cycle after.
